// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, hi, lo, div_zero
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, hi, lo, div_zero
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO. The result is formed at the accept
// edge into a shadow register and committed to HI/LO when the latency counter expires.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);
  localparam int W2      = 2 * WIDTH;
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [W2-1:0]    shadow_q, shadow_d;
  logic             commit_q, commit_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic             accept;
  logic [WIDTH-1:0] a, b;
  logic [W2-1:0]    acc, prod_u, prod_s, a_sx, b_sx;
  logic [WIDTH-1:0] a_mag, b_mag, div_u_b, div_s_b;
  logic [WIDTH-1:0] q_u, r_u, q_mag, r_mag, q_s, r_s;
  logic             b_zero;

  assign accept = bus.start & ~bus.cancel & ~busy_q;
  assign a      = bus.src_a;
  assign b      = bus.src_b;
  assign b_zero = (b == '0);
  assign acc    = {hi_q, lo_q};

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;

  // A zero divisor is replaced by 1 so the dividers never see it; the result is discarded anyway.
  assign div_u_b = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign q_u     = a / div_u_b;
  assign r_u     = a % div_u_b;

  // Signed divide on magnitudes; most-negative / -1 falls out naturally as most-negative, rem 0.
  assign a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag   = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign div_s_b = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag   = a_mag / div_s_b;
  assign r_mag   = a_mag % div_s_b;
  assign q_s     = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~q_mag + 1'b1) : q_mag;
  assign r_s     = a[WIDTH-1] ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    commit_d   = commit_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if ((cnt_q == CNT_W'(1)) && commit_q) begin
        {hi_d, lo_d} = shadow_q;
      end
    end

    if (accept) begin
      case (bus.op)
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        OP_MULTU, OP_MULT, OP_MADD, OP_MSUB: begin
          cnt_d    = CNT_W'(MUL_CYCLES);
          commit_d = 1'b1;
          case (bus.op)
            OP_MULTU: shadow_d = prod_u;
            OP_MULT:  shadow_d = prod_s;
            OP_MADD:  shadow_d = acc + prod_s;
            default:  shadow_d = acc - prod_s;
          endcase
        end
        default: begin
          cnt_d      = CNT_W'(DIV_CYCLES);
          commit_d   = ~b_zero;
          div_zero_d = b_zero;
          shadow_d   = (bus.op == OP_DIVU) ? {r_u, q_u} : {r_s, q_s};
        end
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      shadow_q   <= '0;
      commit_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      shadow_q   <= shadow_d;
      commit_q   <= commit_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

  logic unused_ops;
  assign unused_ops = (OP_DIV != OP_DIVU);
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU in the E stage of the pipelined MIPS core. It accepts one operation per start pulse and holds `busy` for a configurable latency, then commits the 2×WIDTH result to HI/LO. Beyond plain mult/div it supports signed multiply-accumulate and multiply-subtract, direct HI/LO writes, exception cancel of a starting operation, and divide-by-zero reporting. The hazard unit stalls D on `busy` or `start`; W-stage mfhi/mflo reads `hi`/`lo` directly.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 8)
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MSUB (≥ 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥ 1)

- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  E-stage op request, sampled on rising edge
- op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6 MADD (signed), 7 MSUB (signed)
- src_a  input  WIDTH  rs operand, forwarded value
- src_b  input  WIDTH  rt operand, forwarded value
- cancel  input  1  E-stage instruction is being flushed (exception/interrupt); suppresses start this cycle
- busy  output  1  multi-cycle operation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- div_zero  output  1  one-cycle pulse: a divide with src_b = 0 was accepted

## Operation
- Accept = start & ~cancel & ~busy. start while busy or with cancel is ignored entirely; no state change.
- MTHI/MTLO: on accept, hi ← src_a (resp. lo ← src_a) at that edge; busy stays 0; other register untouched.
- MULTU: {hi,lo} ← zero-extended src_a × src_b (2·WIDTH bits).
- MULT: {hi,lo} ← signed src_a × src_b, sign-extended product.
- MADD: {hi,lo} ← {hi,lo} + signed product; MSUB: {hi,lo} ← {hi,lo} − signed product; modulo 2^(2·WIDTH), no overflow flag. Accumulator operand is the {hi,lo} value at the accept edge.
- DIVU: lo ← src_a / src_b, hi ← src_a % src_b, unsigned.
- DIV: quotient truncated toward zero, remainder takes sign of dividend. Most-negative / −1 yields lo = most-negative, hi = 0.
- Divide with src_b = 0: div_zero pulses the cycle after accept; operation still runs DIV_CYCLES busy cycles; hi/lo unchanged at completion.
- Result is computed from operands captured at the accept edge into shadow registers; operand changes while busy have no effect.
- Counter loads MUL_CYCLES or DIV_CYCLES on accept, decrements every edge while nonzero; busy = (counter ≠ 0). On the edge where counter goes 1 → 0, shadow result is written to hi/lo.
- In-flight operations are never aborted by cancel; only the accepting cycle is gated.
- Reset mid-operation: counter, busy, shadow, hi, lo, div_zero all cleared immediately; no pending commit.

## Timing
- Reset values: busy 0, hi 0, lo 0, div_zero 0.
- Accept at edge k (mult/div, latency N): busy = 1 for cycles k+1 … k+N; hi/lo show the new result and busy = 0 from cycle k+N+1.
- Back-to-back: new accept allowed in the first cycle busy = 0 (k+N+1); it sees committed hi/lo (MADD chain correct with no bubbles beyond N).
- MTHI/MTLO: new value visible in cycle k+1; busy never asserted.
- div_zero: high exactly during cycle k+1.
- hi/lo are registered outputs; no combinational path from inputs to any output.

## Test plan
- Reset asserted mid-DIV (counter = 4) -> busy, hi, lo drop to 0 asynchronously before next edge; after release no commit occurs.
- MULT src_a = 0xFFFFFFFE (−2), src_b = 3, default params -> busy 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; MULTU same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
- DIV src_a = 0xFFFFFFF9 (−7), src_b = 2 -> after 10 busy cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- MTHI 5, MTLO 7, then MADD 3×4 back-to-back, then MSUB 2×1 at first non-busy cycle -> hi = 5, lo = 7+12−2 = 0x11.
- start with cancel = 1 (MULT 9×9) -> busy stays 0, hi/lo unchanged; start while busy -> ignored, original result commits on schedule.
- DIVU src_b = 0 with hi = 0xAA, lo = 0xBB -> div_zero pulse in cycle k+1, busy 10 cycles, hi/lo remain 0xAA/0xBB; repeat with WIDTH = 16, MUL_CYCLES = 1 -> MULTU 0xFFFF×0xFFFF gives hi = 0xFFFE, lo = 0x0001 after 1 busy cycle.
